// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch stage: PC, one-outstanding imem reads, FD register, skid buffer
//
// Ports:
//   clk, rst           pipeline clock, synchronous active-high reset
//   stall              hazard-unit stall; holds FD outputs while a valid instruction sits there
//   redirect, pc_jmp   flush FD and restart fetch at {pc_jmp[31:2], 2'b00}
//   imem_req/addr      read request and word address (held until imem_ack)
//   imem_ack/rdata     one-cycle response strobe and instruction word
//   fd_valid/pc/pc4/instr  FD pipeline register contents
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] pc_jmp,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        fd_valid,
  output logic [31:0] fd_pc,
  output logic [31:0] fd_pc4,
  output logic [31:0] fd_instr
);

  // BLOCKED is entered exactly when the skid buffer fills and left exactly
  // when it drains or is flushed, so the state doubles as the skid-full flag.
  typedef enum logic [1:0] {FETCH, BLOCKED, DISCARD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] stale_addr;   // address of the in-flight read being thrown away
  logic [31:0] skid_pc;
  logic [31:0] skid_instr;
  logic [31:0] target;
  logic [31:0] pc_next;
  logic        slot_free;

  assign target    = pc_jmp & 32'hFFFF_FFFC;
  assign pc_next   = pc + 32'd4;
  assign slot_free = !fd_valid || !stall;

  // DISCARD keeps presenting the old address so the pending read completes
  // against a stable request even though pc already holds the new target.
  assign imem_req  = !rst && (state != BLOCKED);
  assign imem_addr = (state == DISCARD) ? stale_addr : pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      stale_addr <= RESET_PC;
      skid_pc    <= 32'h0;
      skid_instr <= 32'h0;
      fd_valid   <= 1'b0;
      fd_pc      <= 32'h0;
      fd_pc4     <= 32'h0;
      fd_instr   <= 32'h0;
    end else if (redirect) begin
      fd_valid <= 1'b0;
      fd_instr <= 32'h0;
      pc       <= target;
      case (state)
        FETCH: begin
          // A read still in flight must be drained before the target is fetched.
          if (!imem_ack) begin
            state      <= DISCARD;
            stale_addr <= pc;
          end
        end
        BLOCKED: state <= FETCH;
        DISCARD: begin
          if (imem_ack) state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack) begin
            pc <= pc_next;
            if (slot_free) begin
              fd_valid <= 1'b1;
              fd_pc    <= pc;
              fd_pc4   <= pc_next;
              fd_instr <= imem_rdata;
            end else begin
              skid_pc    <= pc;
              skid_instr <= imem_rdata;
              state      <= BLOCKED;
            end
          end else if (!stall) begin
            fd_valid <= 1'b0;
          end
        end
        BLOCKED: begin
          if (!stall) begin
            fd_valid <= 1'b1;
            fd_pc    <= skid_pc;
            fd_pc4   <= skid_pc + 32'd4;
            fd_instr <= skid_instr;
            state    <= FETCH;
          end
        end
        DISCARD: begin
          if (imem_ack) state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule
